// File: rtl/accum.sv
// accum: registered ADPCM predictor accumulator producing SEZ and SE
module accum (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] WB1,
  input  logic [15:0] WB2,
  input  logic [15:0] WB3,
  input  logic [15:0] WB4,
  input  logic [15:0] WB5,
  input  logic [15:0] WB6,
  input  logic [15:0] WA1,
  input  logic [15:0] WA2,
  output logic [14:0] SEZ,
  output logic [14:0] SE,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);
  logic [15:0] sezi, sei;
  logic [14:0] sez_d, se_d, sez_q, se_q;
  logic        unused_scan;
  // Sums wrap modulo 2^16; outputs drop the LSB, keeping the sign in bit 14
  always_comb begin
    sezi  = WB1 + WB2 + WB3 + WB4 + WB5 + WB6;
    sei   = sezi + WA1 + WA2;
    sez_d = sezi[15:1];
    se_d  = sei[15:1];
  end
  // Output registers, cleared immediately by reset; scan stitching replaces these later
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sez_q <= '0;
      se_q  <= '0;
    end else begin
      sez_q <= sez_d;
      se_q  <= se_d;
    end
  assign SEZ = sez_q;
  assign SE  = se_q;
  assign {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0} = '0;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode, sezi[0], sei[0]};
endmodule

// File: tb/tb_accum.sv
// tb_accum: scoreboard bench for accum with directed and random stimulus
module tb_accum;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] wb [6];
  logic [15:0] wa [2];
  logic [4:0]  scan_in = '0;
  logic        scan_enable = 1'b0;
  logic        test_mode = 1'b0;
  logic [14:0] SEZ, SE;
  logic [4:0]  scan_out;
  int          total = 0;
  int          bad = 0;
  typedef struct {logic [14:0] sez; logic [14:0] se;} exp_t;
  exp_t        q[$];
  logic [14:0] prev_sez, prev_se;

  accum dut (
    .clk(clk), .reset(reset),
    .WB1(wb[0]), .WB2(wb[1]), .WB3(wb[2]), .WB4(wb[3]), .WB5(wb[4]), .WB6(wb[5]),
    .WA1(wa[0]), .WA2(wa[1]),
    .SEZ(SEZ), .SE(SE),
    .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
    .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out[0]), .scan_out1(scan_out[1]), .scan_out2(scan_out[2]),
    .scan_out3(scan_out[3]), .scan_out4(scan_out[4])
  );

  always #5 clk = ~clk;

  function automatic exp_t model();
    int unsigned z = 0;
    int unsigned s;
    logic [15:0] zt, st;
    exp_t e;
    for (int i = 0; i < 6; i++) z += wb[i];
    s  = z + wa[0] + wa[1];
    zt = z[15:0];
    st = s[15:0];
    e.sez = zt[15:1];
    e.se  = st[15:1];
    return e;
  endfunction

  task automatic chk(input string n, input logic [14:0] act, input logic [14:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  always @(posedge clk)
    if (reset) q.delete();
    else q.push_back(model());

  always @(negedge clk) begin
    chk("scan_out", {10'd0, scan_out}, 15'd0);
    if (reset) begin
      chk("sez_in_reset", SEZ, 15'd0);
      chk("se_in_reset", SE, 15'd0);
      q.delete();
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_sez", SEZ, e.sez);
      chk("sb_se", SE, e.se);
    end
  end

  task automatic step(input logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2,
                      input logic [14:0] esez, ese);
    @(posedge clk);
    #2;
    wb[0] = b1; wb[1] = b2; wb[2] = b3; wb[3] = b4; wb[4] = b5; wb[5] = b6;
    wa[0] = a1; wa[1] = a2;
    #1;
    chk("hold_sez", SEZ, prev_sez);
    chk("hold_se", SE, prev_se);
    @(posedge clk);
    @(negedge clk);
    chk("dir_sez", SEZ, esez);
    chk("dir_se", SE, ese);
    prev_sez = esez;
    prev_se  = ese;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 6; i++) wb[i] = 16'h7FFF;
    wa[0] = 16'h7FFF;
    wa[1] = 16'h7FFF;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_sez", SEZ, 15'd0);
    chk("reset_se", SE, 15'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_sez", SEZ, 15'h7FFD);
    chk("release_se", SE, 15'h7FFC);
    prev_sez = 15'h7FFD;
    prev_se  = 15'h7FFC;
    step(16'h0002, 0, 0, 0, 0, 0, 0, 0, 15'h0001, 15'h0001);
    step(0, 0, 0, 0, 0, 0, 16'h0004, 0, 15'h0000, 15'h0002);
    step(0, 0, 0, 0, 0, 0, 16'h0004, 16'hFFFC, 15'h0000, 15'h0000);
    step(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
         15'h7FFD, 15'h7FFC);
    step(16'hFFFE, 0, 0, 0, 0, 0, 0, 0, 15'h7FFF, 15'h7FFF);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 6; k++) wb[k] = 16'($urandom);
      wa[0] = 16'($urandom);
      wa[1] = 16'($urandom);
      scan_in = 5'($urandom);
      scan_enable = 1'($urandom);
      test_mode = 1'($urandom);
      if (i % 40 == 25) begin
        reset = 1'b1;
        #1;
        chk("async_sez", SEZ, 15'd0);
        chk("async_se", SE, 15'd0);
        chk("async_scan", {10'd0, scan_out}, 15'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
